// File: rtl/apb_rr_master.sv
// apb_rr_master: two-client APB master with round-robin arbitration.
// Each client has a req/done handshake. The master runs SETUP then ACCESS and
// waits on pready for as long as the slave needs.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT wait cycles
// and reports the abort on err_o.
module apb_rr_master #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_i,
  input  logic              rnw0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              rnw1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_last_gnt;

  logic w_any_req;
  logic w_winner;
  logic w_timeout;
  logic w_done;

  // On a tie the client that was not granted last wins; otherwise the lone requester wins.
  assign w_any_req = req0_i | req1_i;
  assign w_winner  = (req0_i & req1_i) ? ~r_last_gnt : req1_i;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] r_to_cnt;

  // Count ACCESS cycles without pready; clear in SETUP so every ACCESS starts at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_to_cnt <= '0;
    end else if ((r_state == ACCESS) && !pready_i) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  // The counter reads TIMEOUT-1 during the TIMEOUT-th waiting cycle; pready wins over abort.
  assign w_timeout = (r_state == ACCESS) && !pready_i && (r_to_cnt == CNT_W'(TIMEOUT - 1));
  assign err_o     = w_timeout;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^32'(TIMEOUT);
  assign w_timeout        = 1'b0;
  assign err_o            = 1'b0;
`endif

  // Completion strobes and read data are combinational during the final ACCESS cycle.
  assign w_done  = (r_state == ACCESS) && (pready_i || w_timeout);
  assign done0_o = w_done & ~r_owner;
  assign done1_o = w_done &  r_owner;
  assign rdata_o = ((r_state == ACCESS) && pready_i && !pwrite_o) ? prdata_i : '0;

  // Bus FSM: capture the winner in IDLE, hold one SETUP cycle, then wait in ACCESS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b1;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      pwrite_o   <= 1'b0;
      paddr_o    <= '0;
      pwdata_o   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= SETUP;
            r_owner    <= w_winner;
            r_last_gnt <= w_winner;
            psel_o     <= 1'b1;
            paddr_o    <= w_winner ? addr1_i  : addr0_i;
            pwrite_o   <= w_winner ? ~rnw1_i  : ~rnw0_i;
            pwdata_o   <= w_winner ? wdata1_i : wdata0_i;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (w_done) begin
            r_state   <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: scoreboard bench for apb_rr_master with a wait-state APB slave model.
// Honors APB_TIMEOUT_EN the same way the design does.
module tb_apb_rr_master;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_i, rnw0_i, req1_i, rnw1_i;
  logic [ADDR_W-1:0] addr0_i, addr1_i;
  logic [DATA_W-1:0] wdata0_i, wdata1_i;
  logic              done0_o, done1_o, err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              psel_o, penable_o, pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;

  apb_rr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_i(req0_i), .rnw0_i(rnw0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .req1_i(req1_i), .rnw1_i(rnw1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .done0_o(done0_o), .done1_o(done1_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } item_t;

  item_t sb[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    waits = 0;
  int    acc_cyc = 0;
  logic [31:0] slv_rdata = '0;
  logic  prev_psel = 1'b0;
  logic  prev_pen  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: pready rises after 'waits' ACCESS cycles.
  always @(posedge clk) begin
    #1;
    if (psel_o && penable_o) begin
      acc_cyc++;
      pready_i = (acc_cyc > waits);
    end else begin
      acc_cyc  = 0;
      pready_i = 1'b0;
    end
    prdata_i = slv_rdata;
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each completion.
  always @(negedge clk) begin
    bit   to_hit;
    bit   compl;
    item_t it;
`ifdef APB_TIMEOUT_EN
    to_hit = psel_o && penable_o && !pready_i && (acc_cyc == int'(TO));
`else
    to_hit = 1'b0;
`endif
    compl = psel_o && penable_o && (pready_i || to_hit);
    if (penable_o && !prev_pen)
      chk("setup_before_access", 64'({prev_psel, prev_pen}), 64'(2'b10));
    if (psel_o && penable_o && sb.size() > 0) begin
      chk("paddr_stable", 64'(paddr_o), 64'(sb[0].addr));
      chk("pwrite_stable", 64'(pwrite_o), 64'(sb[0].wr));
      chk("pwdata_stable", 64'(pwdata_o), 64'(sb[0].wd));
    end
    if (compl) begin
      if (sb.size() == 0) begin
        chk("unexpected_completion", 64'(1), 64'(0));
      end else begin
        it = sb.pop_front();
        chk("done0", 64'(done0_o), 64'(it.c == 0));
        chk("done1", 64'(done1_o), 64'(it.c == 1));
        chk("err", 64'(err_o), 64'(it.err));
        chk("rdata", 64'(rdata_o), 64'(it.rd));
      end
    end else begin
      chk("quiet_outputs", 64'({done0_o, done1_o, err_o, rdata_o}), 64'(0));
    end
    prev_psel = psel_o;
    prev_pen  = penable_o;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0_i = 1'b0;
    req1_i = 1'b0;
    sb.delete();
    repeat (2) tick();
    chk("rst_psel_penable", 64'({psel_o, penable_o}), 64'(0));
    chk("rst_pwrite", 64'(pwrite_o), 64'(0));
    chk("rst_paddr", 64'(paddr_o), 64'(0));
    chk("rst_pwdata", 64'(pwdata_o), 64'(0));
    chk("rst_done_err", 64'({done0_o, done1_o, err_o}), 64'(0));
    chk("rst_rdata", 64'(rdata_o), 64'(0));
    reset = 1'b1;
  endtask

  task automatic xfer(input int c, input bit rd, input logic [9:0] a, input logic [31:0] wd,
                      input logic [31:0] rdv, input int nwait, input int exp_lat,
                      input int exp_pen, input bit exp_err, input bit perturb);
    item_t it;
    int    start;
    int    n;
    int    pen;
    bit    got;
    tick();
    it.c = c; it.wr = !rd; it.addr = a; it.wd = wd;
    it.rd = (rd && !exp_err) ? rdv : 32'h0;
    it.err = exp_err;
    sb.push_back(it);
    waits = nwait;
    slv_rdata = rdv;
    if (c == 0) begin
      req0_i = 1'b1; rnw0_i = rd; addr0_i = a; wdata0_i = wd;
    end else begin
      req1_i = 1'b1; rnw1_i = rd; addr1_i = a; wdata1_i = wd;
    end
    start = cyc;
    n = 0; pen = 0; got = 1'b0;
    while (!got && n < 50) begin
      tick();
      n++;
      if (penable_o) pen++;
      if (perturb && penable_o) begin
        addr0_i  = 10'h3FF;
        wdata0_i = ~wd;
      end
      got = (c == 0) ? done0_o : done1_o;
    end
    chk("done_seen", 64'(got), 64'(1));
    req0_i = 1'b0;
    req1_i = 1'b0;
    chk("latency", 64'(cyc - start), 64'(exp_lat));
    chk("penable_cycles", 64'(pen), 64'(exp_pen));
  endtask

  initial begin
    int dcyc[$];
    int n;
    bit seen;
    item_t it;
    reset = 1'b0;
    req0_i = 1'b0; rnw0_i = 1'b0; addr0_i = '0; wdata0_i = '0;
    req1_i = 1'b0; rnw1_i = 1'b0; addr1_i = '0; wdata1_i = '0;
    do_reset();

    // Single write and wait-state read.
    xfer(0, 1'b0, 10'h004, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1'b0, 1'b0);
    xfer(1, 1'b1, 10'h008, 32'h0, 32'h12345678, 4, 6, 5, 1'b0, 1'b0);

    // Client 0 changes its address mid-transfer; the bus must hold the original.
    xfer(0, 1'b0, 10'h004, 32'h55AA55AA, 32'h0, 3, 5, 4, 1'b0, 1'b1);

    // Reset while ACCESS is waiting.
    tick();
    waits = 1000;
    req0_i = 1'b1; rnw0_i = 1'b1; addr0_i = 10'h020;
    n = 0;
    while (!penable_o && n < 10) begin tick(); n++; end
    chk("reached_access", 64'(penable_o), 64'(1));
    req0_i = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("midreset_bus_idle", 64'({psel_o, penable_o}), 64'(0));
    chk("midreset_no_done", 64'({done0_o, done1_o}), 64'(0));
    reset = 1'b1;
    waits = 0;

    // Contention: first tie after reset goes to client 0, then alternates.
    tick();
    slv_rdata = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      it.c = i % 2;
      it.wr = (i % 2 == 0);
      it.addr = (i % 2 == 0) ? 10'h0AA : 10'h155;
      it.wd = (i % 2 == 0) ? 32'hA5A50000 : 32'h11110000;
      it.rd = (i % 2 == 0) ? 32'h0 : 32'h0BADF00D;
      it.err = 1'b0;
      sb.push_back(it);
    end
    req0_i = 1'b1; rnw0_i = 1'b0; addr0_i = 10'h0AA; wdata0_i = 32'hA5A50000;
    req1_i = 1'b1; rnw1_i = 1'b1; addr1_i = 10'h155; wdata1_i = 32'h11110000;
    n = 0;
    while (dcyc.size() < 4 && n < 100) begin
      tick();
      n++;
      if (done0_o || done1_o) begin
        dcyc.push_back(cyc);
        if (dcyc.size() == 4) begin
          req0_i = 1'b0;
          req1_i = 1'b0;
        end
      end
    end
    req0_i = 1'b0;
    req1_i = 1'b0;
    chk("contention_count", 64'(dcyc.size()), 64'(4));
    for (int i = 1; i < dcyc.size(); i++)
      chk("contention_gap", 64'(dcyc[i] - dcyc[i-1]), 64'(3));
    repeat (3) tick();
    chk("contention_drained", 64'(sb.size()), 64'(0));
    chk("contention_idle", 64'(psel_o), 64'(0));

`ifdef APB_TIMEOUT_EN
    // Slave never answers: abort on the TO-th ACCESS cycle.
    xfer(0, 1'b0, 10'h010, 32'hCAFE0001, 32'h0, 1000, int'(TO) + 1, int'(TO), 1'b1, 1'b0);
    tick();
    chk("timeout_back_idle", 64'({psel_o, penable_o}), 64'(0));
    waits = 0;
`else
    // Slave never answers: master waits indefinitely without error.
    tick();
    waits = 1000;
    req0_i = 1'b1; rnw0_i = 1'b0; addr0_i = 10'h010; wdata0_i = 32'hCAFE0001;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen = seen | done0_o | done1_o | err_o;
    end
    chk("stall_no_done", 64'(seen), 64'(0));
    chk("stall_err", 64'(err_o), 64'(0));
    chk("stall_in_access", 64'({psel_o, penable_o}), 64'(2'b11));
    req0_i = 1'b0;
    do_reset();
    waits = 0;
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-requester APB master that shares one APB slave port (the 10-bit-address / 32-bit-data register slave) between two internal clients.
- Per-client simple req/done handshake; round-robin arbitration; generates the APB SETUP/ACCESS sequence and waits on pready for any number of cycles.
- Sits between the bus clients and the slave's psel/penable/paddr/pwrite/pwdata/prdata/pready pins.

Parameters:
- ADDR_W, 10, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 32, ACCESS-phase cycles before abort (used only with APB_TIMEOUT_EN; legal 1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req0_i / req1_i  in  1  client transfer request
- rnw0_i / rnw1_i  in  1  1 = read, 0 = write
- addr0_i / addr1_i  in  ADDR_W  client address
- wdata0_i / wdata1_i  in  DATA_W  client write data
- done0_o / done1_o  out  1  one-cycle completion pulse
- rdata_o  out  DATA_W  read data, valid only while a done pulse is high
- err_o  out  1  transfer aborted (only with APB_TIMEOUT_EN; else tied 0)
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB write
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- pready_i  in  1  APB ready

Behaviour:
- Reset: reset low at a clk edge -> state IDLE, psel/penable/pwrite = 0, paddr/pwdata = 0, last_gnt = 1. done0/done1/err = 0 and rdata = 0 follow from IDLE. Reset overrides any in-flight transfer; psel drops on that edge; no done pulse is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req is high, pick a winner, go to SETUP.
  - On the same edge, register paddr/pwrite (= ~rnw)/pwdata from the winner, set psel = 1, record owner.
  - With no req, stay in IDLE.
- Arbitration:
  - Only one req high -> that client wins.
  - Both high -> the client not equal to last_gnt wins.
  - last_gnt updates to the winner on the grant edge.
- SETUP: psel = 1, penable = 0, exactly one cycle. Then go to ACCESS with penable = 1.
- ACCESS:
  - psel = penable = 1, while paddr/pwrite/pwdata stay stable.
  - While pready = 0, stay in ACCESS.
  - While pready = 1, done<owner>_o = 1 combinationally. For a read, rdata_o = prdata_i; otherwise rdata_o = 0.
  - Next edge -> IDLE, with psel = penable = 0.
- Client request handling:
  - Client req is sampled only in IDLE. After grant, changes on req/rnw/addr/wdata have no effect on the in-flight transfer.
  - A client must drop req at the edge following its done pulse; a req still high in IDLE is a new transfer.
- Latency: grant edge -> SETUP (1 cycle) -> ACCESS (>= 1 cycle). Minimum 3 cycles from req to done, counted from the cycle req is first high in IDLE. Back-to-back transfers have one IDLE cycle between them (no bus pipelining).
- done0_o and done1_o are never high simultaneously. done is never high outside ACCESS.
- Address and data pass through unmodified at full ADDR_W/DATA_W; no address decode.

Optional Feature:
- Macro: APB_TIMEOUT_EN
- Defined:
  - A counter of width 8 clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - If it reaches TIMEOUT with pready still 0, that cycle asserts done<owner>_o = 1 and err_o = 1, with rdata_o = 0.
  - FSM then returns to IDLE on the next edge, dropping psel/penable.
  - pready = 1 in the same cycle takes priority (normal completion, err_o = 0).
- Undefined: no counter; ACCESS waits indefinitely; err_o tied to 0.

Test Plan:
- Single write: req0 = 1, rnw0 = 0, addr0 = 0x004, wdata0 = 0xDEADBEEF, pready = 1 -> psel 1 cycle before penable; paddr = 0x004, pwrite = 1, pwdata = 0xDEADBEEF; done0 pulses in the 3rd cycle; done1 stays 0.
- Read with wait states: req1 = 1, rnw1 = 1, addr1 = 0x008, pready low for 4 ACCESS cycles then high with prdata = 0x12345678 -> penable high 5 cycles; done1 = 1 with rdata_o = 0x12345678 only in the last cycle.
- Contention: req0 = req1 = 1 held for 4 transfers, pready = 1 -> grant order 0, 1, 0, 1; an idle cycle separates each transfer.
- Stability: change addr0 from 0x004 to 0x3FF during ACCESS -> paddr stays 0x004 until done.
- Reset mid-ACCESS: reset = 0 while ACCESS and pready = 0 -> next edge psel = penable = 0, no done; first tie after reset grants client 0.
- APB_TIMEOUT_EN, TIMEOUT = 8: pready held 0 -> done0 = 1 and err_o = 1 on the 8th ACCESS cycle, rdata_o = 0, then IDLE. Without the macro, same stimulus -> no done after 100 cycles and err_o = 0.
